// File: rtl/pim_model.sv
// pim_model: behavioural processing-in-memory macro.
// A PDEPTH x DWIDTH register array with a combinational read port, a
// clocked write port, and a compute mode that sums every row selected by
// rwl into a registered mac_out (binary-input MAC, modulo 2^DWIDTH).
module pim_model #(
    parameter int unsigned PIM_ADDR_BEGIN = 0,
    parameter int unsigned DWIDTH         = 32,
    parameter int unsigned AWIDTH         = 8,
    parameter int unsigned PWIDTH         = 32,
    parameter int unsigned PDEPTH         = 256
) (
    input  logic              clk,
    input  logic              rst,
    output logic [PWIDTH-1:0] q,
    output logic [DWIDTH-1:0] mac_out,
    input  logic [DWIDTH-1:0] d,
    input  logic [AWIDTH-1:0] addr,
    input  logic [PDEPTH-1:0] rwl,
    input  logic              w_en,
    input  logic              p_en
);

    localparam int unsigned IW = (PDEPTH > 1) ? $clog2(PDEPTH) : 1;

    logic [DWIDTH-1:0] mem [PDEPTH];
    logic [31:0]       addr_ext;
    logic [31:0]       offset;
    logic              in_range;
    logic [IW-1:0]     idx;
    logic [DWIDTH-1:0] rd_word;
    logic [DWIDTH-1:0] mac_sum;

    // Address decode: offset is only meaningful when addr is at or above the base.
    always_comb begin
        addr_ext = 32'(addr);
        offset   = addr_ext - 32'(PIM_ADDR_BEGIN);
        in_range = (addr_ext >= 32'(PIM_ADDR_BEGIN)) && (offset < 32'(PDEPTH));
        idx      = offset[IW-1:0];
    end

    // Asynchronous read of the addressed row; out-of-range reads return zero.
    always_comb begin
        rd_word = '0;
        if (in_range) begin
            rd_word = mem[idx];
        end
    end

    generate
        if (PWIDTH <= DWIDTH) begin : g_q_trunc
            assign q = rd_word[PWIDTH-1:0];
        end else begin : g_q_zext
            assign q = {{(PWIDTH-DWIDTH){1'b0}}, rd_word};
        end
    endgenerate

    // Sum of all rwl-selected rows; wraps naturally at DWIDTH bits.
    always_comb begin
        mac_sum = '0;
        for (int i = 0; i < int'(PDEPTH); i++) begin
            if (rwl[i]) begin
                mac_sum = mac_sum + mem[i];
            end
        end
    end

    // Array update: reset clears every row, otherwise full-word write when in range.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(PDEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (w_en && in_range) begin
            mem[idx] <= d;
        end
    end

    // MAC result register; a concurrent write suppresses the MAC and mac_out holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            mac_out <= '0;
        end else if (p_en && !w_en) begin
            mac_out <= mac_sum;
        end
    end

endmodule

// File: tb/tb_pim_model.sv
// tb_pim_model: directed plus randomized checks of pim_model against an
// array-based reference model. Two instances: base 0 / 256 rows, and
// base 16 / 16 rows for the address-window cases.
module tb_pim_model;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  d;
    logic [7:0]   addr;
    logic [255:0] rwl;
    logic         w_en;
    logic         p_en;
    logic [31:0]  q_a, mac_a, q_b, mac_b;

    int errors = 0;
    int checks = 0;

    logic [31:0] ref_a [256];
    logic [31:0] ref_b [16];
    logic [31:0] ref_mac_a, ref_mac_b;

    always #5 clk = ~clk;

    pim_model #(.PIM_ADDR_BEGIN(0), .DWIDTH(32), .AWIDTH(8), .PWIDTH(32), .PDEPTH(256)) u_dut_a (
        .clk(clk), .rst(rst), .q(q_a), .mac_out(mac_a), .d(d), .addr(addr),
        .rwl(rwl), .w_en(w_en), .p_en(p_en)
    );

    pim_model #(.PIM_ADDR_BEGIN(16), .DWIDTH(32), .AWIDTH(8), .PWIDTH(32), .PDEPTH(16)) u_dut_b (
        .clk(clk), .rst(rst), .q(q_b), .mac_out(mac_b), .d(d), .addr(addr),
        .rwl(rwl[15:0]), .w_en(w_en), .p_en(p_en)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_q_b(input logic [7:0] a);
        if (a >= 8'd16 && a < 8'd32) return ref_b[a - 8'd16];
        return 32'h0;
    endfunction

    // Reference behaviour of one clock edge, using array contents from before the edge.
    task automatic model_edge();
        logic [31:0] sa, sb;
        if (rst) begin
            foreach (ref_a[i]) ref_a[i] = '0;
            foreach (ref_b[i]) ref_b[i] = '0;
            ref_mac_a = '0;
            ref_mac_b = '0;
        end else begin
            if (p_en && !w_en) begin
                sa = 0;
                sb = 0;
                for (int i = 0; i < 256; i++) if (rwl[i]) sa += ref_a[i];
                for (int i = 0; i < 16; i++)  if (rwl[i]) sb += ref_b[i];
                ref_mac_a = sa;
                ref_mac_b = sb;
            end
            if (w_en) begin
                ref_a[addr] = d;
                if (addr >= 8'd16 && addr < 8'd32) ref_b[addr - 8'd16] = d;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("mac_a", mac_a, ref_mac_a);
        check("mac_b", mac_b, ref_mac_b);
    endtask

    task automatic drive(input logic r, input logic w, input logic p,
                         input logic [7:0] a, input logic [31:0] dd, input logic [255:0] rw);
        rst = r; w_en = w; p_en = p; addr = a; d = dd; rwl = rw;
    endtask

    task automatic check_q(input string tag);
        #1;
        check({tag, "_qa"}, q_a, ref_a[addr]);
        check({tag, "_qb"}, q_b, exp_q_b(addr));
    endtask

    initial begin
        foreach (ref_a[i]) ref_a[i] = '0;
        foreach (ref_b[i]) ref_b[i] = '0;
        ref_mac_a = '0;
        ref_mac_b = '0;
        drive(1'b1, 1'b0, 1'b0, 8'd0, 32'h0, '0);
        #2;

        // Reset state
        tick();
        check("rst_mac", mac_a, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 8'd0, 32'h0, '0);
        check_q("rst_a0");
        check("rst_q0", q_a, 32'h0);
        addr = 8'd1;   check_q("rst_a1");
        addr = 8'd255; check_q("rst_a255");
        check("rst_q255", q_a, 32'h0);

        // Basic write and same-cycle read
        drive(1'b0, 1'b1, 1'b0, 8'd0, 32'd5, '0); tick();
        drive(1'b0, 1'b1, 1'b0, 8'd1, 32'd7, '0); tick();
        drive(1'b0, 1'b0, 1'b0, 8'd1, 32'd0, '0); #1;
        check("rd1", q_a, 32'd7);
        addr = 8'd0; #1;
        check("rd0", q_a, 32'd5);

        // MAC of rows 0 and 1, then hold
        drive(1'b0, 1'b0, 1'b1, 8'd0, 32'd0, 256'd3); tick();
        check("mac12", mac_a, 32'd12);
        p_en = 1'b0; tick();
        check("hold12", mac_a, 32'd12);

        // Wraparound and empty select
        drive(1'b0, 1'b1, 1'b0, 8'd0, 32'hFFFF_FFFF, '0); tick();
        drive(1'b0, 1'b1, 1'b0, 8'd1, 32'd2, '0); tick();
        drive(1'b0, 1'b0, 1'b1, 8'd0, 32'd0, 256'd3); tick();
        check("wrap", mac_a, 32'd1);
        rwl = '0; tick();
        check("rwl0", mac_a, 32'd0);

        // Address window of the offset instance
        drive(1'b0, 1'b1, 1'b0, 8'd8, 32'd9, '0); tick();
        w_en = 1'b0; #1;
        check("b_addr8", q_b, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 8'd16, 32'd9, '0); tick();
        w_en = 1'b0; #1;
        check("b_row0", q_b, 32'd9);
        addr = 8'd40; #1;
        check("b_addr40", q_b, 32'h0);
        drive(1'b0, 1'b0, 1'b1, 8'd0, 32'd0, 256'h1_0001); tick();
        check("b_mac", mac_b, 32'd9);

        // Simultaneous write and MAC, then reset mid-sequence
        drive(1'b0, 1'b1, 1'b0, 8'd0, 32'd5, '0); tick();
        drive(1'b0, 1'b1, 1'b0, 8'd1, 32'd7, '0); tick();
        drive(1'b0, 1'b0, 1'b1, 8'd0, 32'd0, 256'd3); tick();
        check("pre12", mac_a, 32'd12);
        drive(1'b0, 1'b1, 1'b1, 8'd2, 32'hABCD_0123, 256'd7); tick();
        check("wp_hold", mac_a, 32'd12);
        w_en = 1'b0; p_en = 1'b0; #1;
        check("wp_word", q_a, 32'hABCD_0123);
        drive(1'b0, 1'b0, 1'b1, 8'd2, 32'd0, 256'd7); tick();
        check("wp_next", mac_a, 32'hABCD_0123 + 32'd12);
        drive(1'b1, 1'b1, 1'b1, 8'd3, 32'h55, 256'd15); tick();
        drive(1'b0, 1'b0, 1'b0, 8'd2, 32'd0, '0); #1;
        check("rst_mid_mac", mac_a, 32'd0);
        check("rst_mid_q", q_a, 32'd0);
        addr = 8'd0; #1;
        check("rst_mid_q0", q_a, 32'd0);

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            logic [255:0] rw;
            for (int k = 0; k < 8; k++) rw[k*32 +: 32] = $urandom;
            drive(($urandom_range(0, 60) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 40)) : 8'($urandom),
                  $urandom, rw);
            check_q("rnd");
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
